// File: rtl/sign_seq_divider.sv
// Sequential signed divider: restoring division on operand magnitudes, one quotient bit per clock.
// Define SIGN_SEQ_DIVIDER_DIVZERO_EN to short-circuit a zero divisor and flag it on DivByZero.
module sign_seq_divider #(
  parameter int INPUT_BIT_WIDTH = 8
) (
  input  logic                       Clk,
  input  logic                       Rst_n,
  input  logic                       Start,
  input  logic [INPUT_BIT_WIDTH-1:0] InputA,
  input  logic [INPUT_BIT_WIDTH-1:0] InputB,
  output logic                       Busy,
  output logic                       Done,
  output logic [INPUT_BIT_WIDTH-1:0] Quotient,
  output logic [INPUT_BIT_WIDTH-1:0] Remainder,
  output logic                       DivByZero
);

  localparam int N  = INPUT_BIT_WIDTH;
  localparam int CW = $clog2(N) + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } state_t;

  state_t          state_r;
  logic [N-1:0]    b_mag_r;
  logic [N-1:0]    rem_r;
  logic [N-1:0]    quo_r;
  logic            sign_a_r;
  logic            sign_b_r;
  logic [CW-1:0]   cnt_r;
`ifdef SIGN_SEQ_DIVIDER_DIVZERO_EN
  logic            dz_r;
`endif

  logic [N:0]      shifted_s;
  logic            ge_s;
  logic [N-1:0]    diff_s;
  logic [N-1:0]    rem_next_s;
  logic [N-1:0]    quo_next_s;
  logic [N-1:0]    quo_fix_s;
  logic [N-1:0]    rem_fix_s;

  // |-2^(N-1)| wraps to the unsigned value 2^(N-1), which still fits N bits
  function automatic logic [N-1:0] mag(input logic [N-1:0] v);
    if (v[N-1]) begin
      return -v;
    end else begin
      return v;
    end
  endfunction

  // One restoring step plus the sign correction applied in FIX
  always_comb begin
    shifted_s  = {rem_r, quo_r[N-1]};
    ge_s       = (shifted_s >= {1'b0, b_mag_r});
    diff_s     = shifted_s[N-1:0] - b_mag_r;
    rem_next_s = shifted_s[N-1:0];
    if (ge_s) begin
      rem_next_s = diff_s;
    end else begin
      rem_next_s = shifted_s[N-1:0];
    end
    quo_next_s = {quo_r[N-2:0], ge_s};
    quo_fix_s  = quo_r;
    if ((sign_a_r ^ sign_b_r) && (quo_r != '0)) begin
      quo_fix_s = -quo_r;
    end else begin
      quo_fix_s = quo_r;
    end
    rem_fix_s = rem_r;
    if (sign_a_r) begin
      rem_fix_s = -rem_r;
    end else begin
      rem_fix_s = rem_r;
    end
  end

  // Control FSM with registered handshake and result outputs
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_r   <= IDLE;
      b_mag_r   <= '0;
      rem_r     <= '0;
      quo_r     <= '0;
      sign_a_r  <= 1'b0;
      sign_b_r  <= 1'b0;
      cnt_r     <= '0;
`ifdef SIGN_SEQ_DIVIDER_DIVZERO_EN
      dz_r      <= 1'b0;
`endif
      Busy      <= 1'b0;
      Done      <= 1'b0;
      Quotient  <= '0;
      Remainder <= '0;
      DivByZero <= 1'b0;
    end else begin
      Done <= 1'b0;
      case (state_r)
        IDLE: begin
          if (Start) begin
            b_mag_r  <= mag(InputB);
            sign_a_r <= InputA[N-1];
            sign_b_r <= InputB[N-1];
            cnt_r    <= '0;
            Busy     <= 1'b1;
`ifdef SIGN_SEQ_DIVIDER_DIVZERO_EN
            if (InputB == '0) begin
              // Remainder path reuses the sign fix-up to reproduce InputA
              rem_r   <= mag(InputA);
              quo_r   <= '0;
              dz_r    <= 1'b1;
              state_r <= FIX;
            end else begin
              rem_r   <= '0;
              quo_r   <= mag(InputA);
              dz_r    <= 1'b0;
              state_r <= CALC;
            end
`else
            rem_r   <= '0;
            quo_r   <= mag(InputA);
            state_r <= CALC;
`endif
          end else begin
            state_r <= IDLE;
          end
        end
        CALC: begin
          rem_r <= rem_next_s;
          quo_r <= quo_next_s;
          cnt_r <= cnt_r + CW'(1);
          if (cnt_r == CW'(N - 1)) begin
            state_r <= FIX;
          end else begin
            state_r <= CALC;
          end
        end
        FIX: begin
`ifdef SIGN_SEQ_DIVIDER_DIVZERO_EN
          if (dz_r) begin
            Quotient <= '0;
          end else begin
            Quotient <= quo_fix_s;
          end
          DivByZero <= dz_r;
`else
          Quotient  <= quo_fix_s;
          DivByZero <= 1'b0;
`endif
          Remainder <= rem_fix_s;
          Done      <= 1'b1;
          Busy      <= 1'b0;
          state_r   <= IDLE;
        end
        default: begin
          state_r <= IDLE;
          Busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/sign_seq_divider.md
SIGN_SEQ_DIVIDER -- requirements
Module: sign_seq_divider

Interface
REQ-001 SHALL have parameter INPUT_BIT_WIDTH, default 8, giving the operand and result width N (N >= 2).
REQ-002 SHALL have port Clk  input  1  single clock; all state changes on rising edge.
REQ-003 SHALL have port Rst_n  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port Start  input  1  request a division; sampled on rising Clk.
REQ-005 SHALL have port InputA  input  N  signed two's-complement dividend.
REQ-006 SHALL have port InputB  input  N  signed two's-complement divisor.
REQ-007 SHALL have port Busy  output  1  high while a division is in progress.
REQ-008 SHALL have port Done  output  1  one-cycle pulse marking new results valid.
REQ-009 SHALL have port Quotient  output  N  signed quotient, held until the next Done.
REQ-010 SHALL have port Remainder  output  N  signed remainder, held until the next Done.
REQ-011 SHALL have port DivByZero  output  1  qualifies the result presented with the current Done.

Function
REQ-012 SHALL implement FSM states IDLE, CALC and FIX, with reset state IDLE.
REQ-013 SHALL, in IDLE, on Start=1 capture |InputA|, |InputB| and both sign bits, assert Busy, and enter CALC.
REQ-014 SHALL ignore Start outside IDLE; the captured operands do not change while Busy=1.
REQ-015 SHALL, in CALC, run restoring division on the N-bit unsigned magnitudes, one quotient bit per cycle, for exactly N cycles, then enter FIX.
REQ-016 SHALL, in FIX, sign-correct the results, load Quotient and Remainder, pulse Done=1, drop Busy, and return to IDLE, all on the same edge.
REQ-017 SHALL assert Done in the cycle following edge k+N+1, where edge k is the one that accepts Start; latency is N+1 clocks.
REQ-018 SHALL truncate the quotient toward zero: Quotient is negative iff the operand signs differ and the quotient magnitude is nonzero.
REQ-019 SHALL give Remainder the sign of the dividend, with |Remainder| < |InputB|.
REQ-020 SHALL take |-2^(N-1)| as the unsigned value 2^(N-1) and wrap results modulo 2^N; for N=8, -128 / -1 gives Quotient=-128, Remainder=0.
REQ-021 SHALL accept a Start that coincides with a Done cycle, because the FSM is already in IDLE.
REQ-022 SHALL keep DivByZero=0 for every nonzero divisor.

Reset
REQ-023 SHALL, while Rst_n=0, asynchronously force the state to IDLE and drive Busy=0, Done=0, DivByZero=0, Quotient=0 and Remainder=0.
REQ-024 SHALL, on reset during CALC or FIX, abandon the operation with no Done pulse; the first Start after reset release behaves normally.

Configuration
REQ-025 SHALL, when macro SIGN_SEQ_DIVIDER_DIVZERO_EN is defined, on a Start with InputB=0 skip CALC and enter FIX directly.
REQ-026 In that case SHALL pulse Done one clock after the capture edge with DivByZero=1, Quotient=0 and Remainder=InputA.
REQ-027 SHALL, when SIGN_SEQ_DIVIDER_DIVZERO_EN is undefined, tie DivByZero to 0 and run divisor 0 through the normal path: InputA>=0 gives Quotient=-1 (all ones), Remainder=InputA; InputA<0 gives Quotient=1, Remainder=InputA.

Verification (N=8)
REQ-028 SHALL cover: InputA=20, InputB=8, Start pulse -> Busy for 9 clocks, then Done=1 for one cycle with Quotient=2, Remainder=4.
REQ-029 SHALL cover: -20/8 -> Quotient=-2, Remainder=-4; 20/-8 -> Quotient=-2, Remainder=4; -20/-8 -> Quotient=2, Remainder=-4.
REQ-030 SHALL cover: -128/-1 -> Quotient=-128, Remainder=0; -128/1 -> Quotient=-128, Remainder=0; 5/7 -> Quotient=0, Remainder=5.
REQ-031 SHALL cover: 20/8 followed by Start with 100/3 on the 4th Busy cycle -> the second request is ignored and results are 2/4; Start with 100/3 on the Done cycle -> the next Done gives Quotient=33, Remainder=1.
REQ-032 SHALL cover: Rst_n=0 for one cycle during the 5th CALC cycle -> all outputs 0, no Done pulse; a new 20/8 request then completes with 2/4.
REQ-033 SHALL cover: 20/0 with the macro defined -> Done one clock after capture, DivByZero=1, Quotient=0, Remainder=20; without the macro -> Done after 9 clocks, DivByZero=0, Quotient=-1, Remainder=20.
